// File: rtl/ps_pkg.sv
// Shared constants and state encoding for the parallel/serial shift controller.
package ps_pkg;

  localparam int BITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/ps_shift_reg.sv
// Loadable shift register: SEL=0 loads Din, SEL=1 shifts Din_serie into the MSB.
module ps_shift_reg
  import ps_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            SEL,
  input  logic            Din_serie,
  input  logic [BITS-1:0] Din,
  output logic [BITS-1:0] Dout
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      Dout <= '0;
    end else if (en) begin
      Dout <= SEL ? {Din_serie, Dout[BITS-1:1]} : Din;
    end
  end

endmodule

// File: rtl/ps_shift_ctrl.sv
// Frame controller: accepts a parallel word, shifts it out LSB first while
// capturing BITS serial bits, then reports the received word for one cycle.
module ps_shift_ctrl
  import ps_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            in_ready,
  input  logic            tick,
  input  logic            ser_in,
  output logic            ser_out,
  output logic            ser_valid,
  output logic [BITS-1:0] rx_data,
  output logic            rx_valid,
  output logic            busy
);

  localparam int            CW   = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [BITS-1:0] sr_q;
  logic            sr_en, sr_sel;
  logic            load, shift, last;

  ps_shift_reg #(.BITS(BITS)) u_shift_reg (
    .clk       (clk),
    .reset     (reset),
    .en        (sr_en),
    .SEL       (sr_sel),
    .Din_serie (ser_in),
    .Din       (in_data),
    .Dout      (sr_q)
  );

  assign last    = (cnt_q == LAST);
  assign ser_out = sr_q[0];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    ser_valid = 1'b0;
    rx_valid  = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = tick;
        if (tick) begin
          shift = 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        rx_valid = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    sr_en  = load | shift;
    sr_sel = shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_data <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q <= '0;
      end else if (shift) begin
        // Wrap on the final shift so the count never passes BITS-1.
        cnt_q <= last ? '0 : cnt_q + 1'b1;
        if (last) rx_data <= {ser_in, sr_q[BITS-1:1]};
      end
    end
  end

endmodule

// File: doc/ps_shift_ctrl.md
PS_SHIFT_CTRL -- requirements
Module: ps_shift_ctrl

Interface
- REQ-001: The block SHALL have parameter BITS, default 4, setting the word width and the shift count per frame.
- REQ-002: Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003: Port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
- REQ-004: Port in_valid, input, 1 bit: a parallel word is offered on in_data.
- REQ-005: Port in_data, input, BITS bits: the parallel word to transmit.
- REQ-006: Port in_ready, output, 1 bit: the block accepts a word this cycle.
- REQ-007: Port tick, input, 1 bit: bit-rate enable; one shift per cycle in which tick=1.
- REQ-008: Port ser_in, input, 1 bit: the serial receive bit, shifted into the MSB.
- REQ-009: Port ser_out, output, 1 bit: the current transmit bit, always equal to the shift register LSB.
- REQ-010: Port ser_valid, output, 1 bit: ser_out is consumed on this edge.
- REQ-011: Port rx_data, output, BITS bits: the last fully captured receive word.
- REQ-012: Port rx_valid, output, 1 bit: one-cycle pulse when rx_data is updated.
- REQ-013: Port busy, output, 1 bit: a frame is in progress.

Function
- REQ-014: The FSM SHALL have three states: IDLE, SHIFT and DONE.
- REQ-015: in_ready SHALL equal (state==IDLE), decoded from state only, with no combinational path from in_valid.
- REQ-016: IDLE: on in_valid&in_ready at an edge, the shift register SHALL load in_data, the counter SHALL clear to 0, and the next state SHALL be SHIFT.
- REQ-017: IDLE without in_valid: the block SHALL hold its state; the register holds its value.
- REQ-018: SHIFT: ser_valid SHALL equal tick.
- REQ-019: SHIFT with tick=1: at the edge the register SHALL become {ser_in, reg[BITS-1:1]} and the counter SHALL increment.
- REQ-020: SHIFT with tick=0: the register and counter SHALL hold.
- REQ-021: SHIFT with tick=1 and counter==BITS-1: the block SHALL perform the final shift, set rx_data<={ser_in, reg[BITS-1:1]}, and go to DONE.
- REQ-022: DONE: rx_valid SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE unconditionally, regardless of tick.
- REQ-023: ser_valid SHALL be 0 outside SHIFT.
- REQ-024: Bits SHALL be transmitted LSB first.
- REQ-025: The block SHALL transmit exactly BITS bits per frame.
- REQ-026: in_valid SHALL be ignored in SHIFT and DONE; no word is lost, because in_ready=0 in those states.
- REQ-027: busy SHALL equal (state!=IDLE).
- REQ-028: rx_data SHALL hold its value between captures.
- REQ-029: The counter SHALL be $clog2(BITS) bits wide and SHALL never exceed BITS-1.
- REQ-030: With tick held 1, a frame SHALL take BITS+2 cycles from accept edge to the next possible accept edge.

Reset
- REQ-031: Reset SHALL force state=IDLE, shift register=0, counter=0 and rx_data=0.
- REQ-032: After reset, outputs SHALL be in_ready=1, ser_out=0, ser_valid=0, rx_valid=0 and busy=0.
- REQ-033: Reset SHALL take priority over in_valid and tick on the same edge.
- REQ-034: Reset mid-frame SHALL discard the frame with no rx_valid pulse.

Structure
- REQ-035: Package ps_pkg SHALL hold the BITS default constant and the state enum typedef (IDLE/SHIFT/DONE).
- REQ-036: The shift register SHALL be a sub-module ps_shift_reg (clk, reset, SEL, Din_serie, Din, Dout).
- REQ-037: ps_shift_reg SHALL use synchronous reset and an enable; its SEL input SHALL be 0 for load and 1 for shift.
- REQ-038: The FSM, counter and rx_data register SHALL live in ps_shift_ctrl.

Verification
- REQ-039: Basic frame: BITS=4, in_data=4'b1011, tick=1, ser_in=0, accept at edge 0 -> ser_out=1,1,0,1 with ser_valid=1 over the four cycles; rx_valid=1 in the cycle after edge 4 with rx_data=4'b0000; in_ready=1 after edge 5.
- REQ-040: Loopback: ser_in tied to ser_out, in_data=4'b0110 -> rx_data=4'b0110, exactly one rx_valid pulse.
- REQ-041: Tick gating: tick=1 every 3rd cycle, in_data=4'b1001 -> exactly 4 ser_valid pulses; ser_out stable between ticks; DONE reached after the 4th tick.
- REQ-042: Back-pressure: in_valid held 1 with new data during SHIFT -> in_ready=0, the frame is unaffected, and the second word is accepted at the first IDLE edge.
- REQ-043: Reset mid-frame: reset asserted after 2 shifts -> next cycle busy=0, in_ready=1, ser_valid=0, no rx_valid, and rx_data unchanged at 0.
- REQ-044: Reset with in_valid=1 on the same edge -> the word is not loaded and the state is IDLE.
